ps2_host_tx: RTL

//   Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting) from the CPU side
//   to the mouse over the shared open-drain PS2_CLK/PS2_DAT lines. It is the transmit counterpart of the

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 48 ++++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and command constants for the PS/2 host transmitter
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        STOP      = 3'd4,
        ACK       = 3'd5,
        WAIT_IDLE = 3'd6
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_DISABLE  = 8'hF5;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_sync
// Brief    : PS/2 clock/data synchronizer with registered falling-edge strobe
// Revision : 1.0
// ============================================================================
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] r_clk_sh;
    logic [SYNC_STAGES-1:0] r_dat_sh;
    logic                   r_clk_d;
    logic                   r_fall;

    // Idle bus level is high, so the chains reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sh <= '1;
            r_dat_sh <= '1;
            r_clk_d  <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_clk_sh[0] <= clk_in;
            r_dat_sh[0] <= dat_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_sh[i] <= r_clk_sh[i-1];
                r_dat_sh[i] <= r_dat_sh[i-1];
            end
            r_clk_d <= r_clk_sh[SYNC_STAGES-1];
            r_fall  <= r_clk_d & ~r_clk_sh[SYNC_STAGES-1];
        end
    end

    assign clk_sync = r_clk_sh[SYNC_STAGES-1];
    assign dat_sync = r_dat_sh[SYNC_STAGES-1];
    assign clk_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : Host-to-device PS/2 byte transmitter with request-to-send and ack
// Revision : 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       ack_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_t    r_state;
    ps2_tx_state_t    w_next;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [3:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_dat_drive;
    logic             r_ack_err;

    logic w_clk_sync;
    logic w_dat_sync;
    logic w_fall;
    logic w_done;
    logic w_error;
    logic w_timeout;
    logic w_to_active;
    logic w_accept;

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (ps2_clk_in),
        .dat_in   (ps2_dat_in),
        .clk_sync (w_clk_sync),
        .dat_sync (w_dat_sync),
        .clk_fall (w_fall)
    );

    assign w_accept    = (r_state == IDLE) && tx_valid;
    assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign w_to_active = (r_state == SEND) || (r_state == STOP) ||
                         (r_state == ACK)  || (r_state == WAIT_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_error    = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_valid) w_next = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) w_next = REQ;
            end
            REQ: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                w_next     = SEND;
            end
            SEND: begin
                ps2_dat_oe = r_dat_drive;
                if (w_timeout) begin
                    w_error = 1'b1;
                    w_next  = IDLE;
                end else if (w_fall && (r_bit_cnt == 4'd9)) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (w_timeout) begin
                    w_error = 1'b1;
                    w_next  = IDLE;
                end else if (w_clk_sync) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                // A clock edge seen on the timeout cycle still resolves the ack.
                if (w_fall) begin
                    if (!w_dat_sync) begin
                        w_next = WAIT_IDLE;
                    end else begin
                        w_error = 1'b1;
                        w_next  = IDLE;
                    end
                end else if (w_timeout) begin
                    w_error = 1'b1;
                    w_next  = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_sync && w_dat_sync) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_parity    <= 1'b0;
            r_bit_cnt   <= 4'd0;
            r_inh_cnt   <= '0;
            r_to_cnt    <= '0;
            r_dat_drive <= 1'b0;
            r_ack_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data    <= tx_data;
                r_parity  <= odd_parity(tx_data);
                r_ack_err <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_inh_cnt <= '0;
            end

            if ((r_state == INHIBIT) && (r_inh_cnt != INH_W'(INHIBIT_CYCLES))) begin
                r_inh_cnt <= r_inh_cnt + 1'b1;
            end

            if (r_state == REQ) begin
                r_to_cnt    <= '0;
                r_dat_drive <= 1'b1;
            end else if (w_to_active && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // Line driven low for a 0 bit; after parity the stop bit is released.
            if ((r_state == SEND) && w_fall) begin
                if (r_bit_cnt < 4'd8) begin
                    r_dat_drive <= ~r_data[r_bit_cnt[2:0]];
                end else if (r_bit_cnt == 4'd8) begin
                    r_dat_drive <= ~r_parity;
                end else begin
                    r_dat_drive <= 1'b0;
                end
                if (r_bit_cnt != 4'd15) r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_error) r_ack_err <= 1'b1;
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign done     = w_done;
    assign error    = w_error;
    assign ack_err  = r_ack_err;

endmodule
`default_nettype wire
